// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C byte sequencer and its quarter-period timer.
package i2c_pkg;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_STOP  = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_START = 3'd2,
        S_BIT   = 3'd3,
        S_STOP  = 3'd4,
        S_RESP  = 3'd5
    } seq_state_e;

    localparam int BITS_PER_BYTE = 9;
    localparam int PHASES        = 4;

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-bit timebase with SCL stretch freeze; I2C_STRETCH_TIMEOUT_EN adds an abort
// after TIMEOUT_CYC consecutive frozen cycles.
module i2c_quarter_timer
    import i2c_pkg::*;
#(
    parameter int DIVIDER     = 10000,
    parameter int CBITS       = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       load,
    input  logic [1:0] load_phase,
    input  logic       scl_rel,
    input  logic       scl_in,
    output logic [1:0] phase,
    output logic       phase_last,
    output logic       stretch_abort
);

    if (DIVIDER < 2 || (2 ** CBITS) <= DIVIDER || TIMEOUT_CYC < 1 || PHASES != 4) begin : g_bad_cfg
        $error("i2c_quarter_timer: illegal parameter set");
    end

    logic [CBITS-1:0] q_cnt;
    logic             freeze;

    // A released SCL that still reads low is a slave stretching the clock.
    assign freeze     = run && scl_rel && !scl_in;
    assign phase_last = run && !freeze && (q_cnt == CBITS'(DIVIDER - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            q_cnt <= '0;
            phase <= 2'd0;
        end else if (load) begin
            q_cnt <= '0;
            phase <= load_phase;
        end else if (run && !freeze) begin
            if (phase_last) begin
                q_cnt <= '0;
                phase <= phase + 2'd1;
            end else begin
                q_cnt <= q_cnt + 1'b1;
            end
        end
    end

`ifdef I2C_STRETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] st_cnt;

    always_ff @(posedge clk) begin
        if (rst || !freeze) st_cnt <= '0;
        else                st_cnt <= st_cnt + 1'b1;
    end

    assign stretch_abort = freeze && (st_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign stretch_abort = 1'b0;
`endif

endmodule

// File: rtl/i2c_byte_sequencer.sv
// Command-driven single-master I2C sequencer (START/WRITE/READ/STOP) driving open-drain
// enables; optional stretch timeout under I2C_STRETCH_TIMEOUT_EN.
module i2c_byte_sequencer
    import i2c_pkg::*;
#(
    parameter int DIVIDER     = 10000,
    parameter int CBITS       = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_ack,
    output logic       rsp_err,
    output logic       rsp_timeout,
    output logic       bus_owned,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);

    localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE - 1);

    seq_state_e state, state_d;
    cmd_op_e    op_r;
    logic [3:0] bit_idx;
    logic [7:0] wbyte, rdata;
    logic       nack_r, ack_r, err_r, sda_hold;
    logic       accept, run, tmr_load, bit_sda;
    logic [1:0] load_phase, phase;
    logic       phase_last, stretch_abort;

    assign accept    = cmd_valid && cmd_ready;
    assign run       = (state == S_START) || (state == S_BIT) || (state == S_STOP);
    assign rsp_valid = (state == S_RESP);
    assign rsp_rdata = rdata;
    assign rsp_ack   = ack_r;
    assign rsp_err   = err_r;

    // Bit 8 is the ACK slot: master releases it on WRITE, drives ~nack on READ.
    assign bit_sda = (bit_idx == LAST_BIT) ? (op_r == OP_READ && !nack_r)
                                           : (op_r == OP_WRITE && !wbyte[7]);

    i2c_quarter_timer #(
        .DIVIDER    (DIVIDER),
        .CBITS      (CBITS),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .load         (tmr_load),
        .load_phase   (load_phase),
        .scl_rel      (!scl_oe),
        .scl_in       (scl_in),
        .phase        (phase),
        .phase_last   (phase_last),
        .stretch_abort(stretch_abort)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d    = state;
        cmd_ready  = 1'b0;
        scl_oe     = 1'b0;
        sda_oe     = 1'b0;
        tmr_load   = 1'b0;
        load_phase = 2'd0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_op_e'(cmd_op) == OP_START) begin
                        state_d    = S_START;
                        tmr_load   = 1'b1;
                        load_phase = 2'd1;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                cmd_ready = 1'b1;
                scl_oe    = 1'b1;
                sda_oe    = sda_hold;
                if (cmd_valid) begin
                    tmr_load = 1'b1;
                    case (cmd_op_e'(cmd_op))
                        OP_START: state_d = S_START;
                        OP_STOP:  state_d = S_STOP;
                        default:  state_d = S_BIT;
                    endcase
                end
            end
            S_START: begin
                scl_oe = (phase == 2'd0) || (phase == 2'd3);
                sda_oe = phase[1];
                if (phase_last && phase == 2'd3) state_d = S_RESP;
            end
            S_BIT: begin
                scl_oe = (phase == 2'd0) || (phase == 2'd3);
                sda_oe = bit_sda;
                if (phase_last && phase == 2'd3 && bit_idx == LAST_BIT) state_d = S_RESP;
            end
            S_STOP: begin
                scl_oe = (phase == 2'd0);
                sda_oe = (phase != 2'd3);
                if (phase_last && phase == 2'd3) state_d = S_RESP;
            end
            S_RESP: begin
                scl_oe  = bus_owned;
                sda_oe  = sda_hold;
                state_d = bus_owned ? S_WAIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (stretch_abort) state_d = S_RESP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r      <= OP_START;
            bit_idx   <= 4'd0;
            wbyte     <= 8'd0;
            rdata     <= 8'd0;
            nack_r    <= 1'b0;
            ack_r     <= 1'b0;
            err_r     <= 1'b0;
            bus_owned <= 1'b0;
            sda_hold  <= 1'b0;
        end else begin
            // WAIT and RESP replay sda_hold, so tracking sda_oe every cycle keeps it stable.
            sda_hold <= sda_oe;
            if (accept) begin
                op_r    <= cmd_op_e'(cmd_op);
                wbyte   <= cmd_wdata;
                nack_r  <= cmd_nack;
                bit_idx <= 4'd0;
                ack_r   <= 1'b0;
                err_r   <= (state == S_IDLE) && (cmd_op_e'(cmd_op) != OP_START);
            end
            if (state == S_BIT && phase_last) begin
                if (phase == 2'd2) begin
                    if (op_r == OP_READ && bit_idx != LAST_BIT) rdata <= {rdata[6:0], sda_in};
                    if (op_r == OP_WRITE && bit_idx == LAST_BIT) ack_r <= sda_in;
                end
                if (phase == 2'd3) begin
                    bit_idx <= bit_idx + 4'd1;
                    wbyte   <= {wbyte[6:0], 1'b0};
                end
            end
            if (state == S_START && phase_last && phase == 2'd3) bus_owned <= 1'b1;
            if (state == S_STOP && phase_last && phase == 2'd3)  bus_owned <= 1'b0;
            if (stretch_abort) begin
                bus_owned <= 1'b0;
                sda_hold  <= 1'b0;
            end
        end
    end

`ifdef I2C_STRETCH_TIMEOUT_EN
    logic timeout_r;
    always_ff @(posedge clk) begin
        if (rst)                timeout_r <= 1'b0;
        else if (accept)        timeout_r <= 1'b0;
        else if (stretch_abort) timeout_r <= 1'b1;
    end
    assign rsp_timeout = timeout_r;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Directed bench for i2c_byte_sequencer at DIVIDER=4 with a bit-counting slave model.
module tb_i2c_byte_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_nack;
    logic [1:0] cmd_op;
    logic [7:0] cmd_wdata, rsp_rdata;
    logic       rsp_valid, rsp_ack, rsp_err, rsp_timeout, bus_owned;
    logic       scl_oe, sda_oe, scl_in, sda_in;
    logic       stretch, slave_low;

    int tests = 0;
    int fails = 0;

    // Results recorded by exec
    int         lat, bitcnt, stall_left;
    logic [8:0] pat;
    logic       any_act, stop_edge, sda_glitch, scl_moved;
    logic       r_scl, r_sda, r_bus, r_rdy, r_rv;

    always #5 clk = ~clk;

    assign scl_in = ~scl_oe & ~stretch;
    assign sda_in = ~sda_oe & ~slave_low;

    i2c_byte_sequencer #(.DIVIDER(4), .CBITS(4), .TIMEOUT_CYC(20)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_wdata(cmd_wdata), .cmd_nack(cmd_nack),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_ack(rsp_ack),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .bus_owned(bus_owned),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in), .sda_in(sda_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command and follow it to rsp_valid (lat = negedges after the accept edge).
    task automatic exec(input logic [1:0] op, input logic [7:0] wd, input logic nk,
                        input int mode, input logic [7:0] sdata,
                        input int stall_bit, input int stall_len, input int abort_bit);
        logic pscl, psda, stalled, held_scl;
        int   n;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        cmd_valid = 1'b1; cmd_op = op; cmd_wdata = wd; cmd_nack = nk;
        lat = -1; bitcnt = 0; pat = '0; any_act = 1'b0; stop_edge = 1'b0;
        sda_glitch = 1'b0; scl_moved = 1'b0; stalled = 1'b0; stall_left = 0;
        pscl = scl_oe; psda = sda_oe; held_scl = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (n = 1; n < 1000; n++) begin
            if (rsp_valid) begin lat = n; break; end
            if (!pscl && scl_oe) bitcnt++;
            any_act = any_act | scl_oe | sda_oe;
            if (!scl_oe && !pscl && psda && !sda_oe) stop_edge = 1'b1;
            if ((op == 2'd1 || op == 2'd2) && !scl_oe && !pscl && sda_oe != psda) sda_glitch = 1'b1;
            if (!scl_oe && bitcnt < 9) pat[bitcnt] = sda_oe;
            slave_low = 1'b0;
            if (mode == 1 && bitcnt == 8) slave_low = 1'b1;
            if (mode == 2 && bitcnt < 8)  slave_low = !sdata[7-bitcnt];
            if (stall_left > 0) begin
                if (scl_oe != held_scl) scl_moved = 1'b1;
                stall_left--;
                if (stall_left == 0) stretch = 1'b0;
            end else if (!stalled && bitcnt == stall_bit && !scl_oe) begin
                stretch = 1'b1; stall_left = stall_len; stalled = 1'b1; held_scl = scl_oe;
            end
            if (abort_bit >= 0 && bitcnt == abort_bit && !scl_oe) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                r_scl = scl_oe; r_sda = sda_oe; r_bus = bus_owned;
                r_rdy = cmd_ready; r_rv = rsp_valid;
                break;
            end
            pscl = scl_oe; psda = sda_oe;
            @(negedge clk);
        end
        stretch = 1'b0; slave_low = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_wdata = 8'd0; cmd_nack = 1'b0;
        stretch = 1'b0; slave_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_bus_owned", bus_owned, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_timeout", rsp_timeout, 0);
        rst = 1'b0;

        exec(2'd0, 8'h00, 1'b0, 0, 8'h00, -1, 0, -1);
        chk("start_idle_lat", lat, 13);
        chk("start_bus_owned", bus_owned, 1);
        chk("start_err", rsp_err, 0);
        @(negedge clk);
        chk("wait_scl", scl_oe, 1);
        chk("wait_sda", sda_oe, 1);
        chk("wait_ready", cmd_ready, 1);

        exec(2'd1, 8'hA5, 1'b0, 1, 8'h00, -1, 0, -1);
        chk("wr_a5_lat", lat, 145);
        chk("wr_a5_pattern", pat, 9'h05A);
        chk("wr_a5_ack", rsp_ack, 0);
        chk("wr_a5_glitch", sda_glitch, 0);
        chk("wr_a5_bus_owned", bus_owned, 1);

        exec(2'd1, 8'h3C, 1'b0, 0, 8'h00, -1, 0, -1);
        chk("wr_3c_pattern", pat, 9'h0C3);
        chk("wr_3c_nack", rsp_ack, 1);

        exec(2'd2, 8'h00, 1'b0, 2, 8'hC5, -1, 0, -1);
        chk("rd_c5_lat", lat, 145);
        chk("rd_c5_data", rsp_rdata, 8'hC5);
        chk("rd_c5_pattern", pat, 9'h100);
        chk("rd_c5_ack", rsp_ack, 0);

        exec(2'd2, 8'h00, 1'b1, 2, 8'h3C, -1, 0, -1);
        chk("rd_3c_data", rsp_rdata, 8'h3C);
        chk("rd_3c_pattern", pat, 9'h000);
        chk("rd_3c_glitch", sda_glitch, 0);

        exec(2'd1, 8'hA5, 1'b0, 1, 8'h00, 3, 10, -1);
        chk("stretch_lat", lat, 155);
        chk("stretch_scl_held", scl_moved, 0);
        chk("stretch_pattern", pat, 9'h05A);
        chk("stretch_ack", rsp_ack, 0);

        exec(2'd0, 8'h00, 1'b0, 0, 8'h00, -1, 0, -1);
        chk("rstart_lat", lat, 17);
        chk("rstart_bus_owned", bus_owned, 1);

        exec(2'd3, 8'h00, 1'b0, 0, 8'h00, -1, 0, -1);
        chk("stop_lat", lat, 17);
        chk("stop_bus_owned", bus_owned, 0);
        chk("stop_sda_rise", stop_edge, 1);
        @(negedge clk);
        chk("idle_scl", scl_oe, 0);
        chk("idle_sda", sda_oe, 0);
        chk("idle_ready", cmd_ready, 1);

        exec(2'd1, 8'hFF, 1'b0, 0, 8'h00, -1, 0, -1);
        chk("ill_wr_lat", lat, 1);
        chk("ill_wr_err", rsp_err, 1);
        chk("ill_wr_activity", any_act, 0);
        chk("ill_wr_bus", bus_owned, 0);
        exec(2'd3, 8'h00, 1'b0, 0, 8'h00, -1, 0, -1);
        chk("ill_stop_err", rsp_err, 1);
        exec(2'd2, 8'h00, 1'b0, 0, 8'h00, -1, 0, -1);
        chk("ill_rd_err", rsp_err, 1);
        chk("ill_rd_lat", lat, 1);

        exec(2'd0, 8'h00, 1'b0, 0, 8'h00, -1, 0, -1);
        chk("start2_lat", lat, 13);
        chk("start2_err_clr", rsp_err, 0);

        exec(2'd1, 8'h5A, 1'b0, 0, 8'h00, -1, 0, 5);
        chk("rst_mid_scl", r_scl, 0);
        chk("rst_mid_sda", r_sda, 0);
        chk("rst_mid_bus", r_bus, 0);
        chk("rst_mid_ready", r_rdy, 1);
        chk("rst_mid_rv", r_rv, 0);
        rst = 1'b0;
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (rsp_valid || scl_oe || sda_oe) seen++;
        end
        chk("rst_mid_quiet", seen, 0);

`ifdef I2C_STRETCH_TIMEOUT_EN
        exec(2'd0, 8'h00, 1'b0, 0, 8'h00, -1, 0, -1);
        exec(2'd1, 8'hA5, 1'b0, 0, 8'h00, 3, 1000, -1);
        chk("to_lat", lat, 73);
        chk("to_flag", rsp_timeout, 1);
        chk("to_bus", bus_owned, 0);
        chk("to_scl", scl_oe, 0);
        chk("to_sda", sda_oe, 0);
        @(negedge clk);
        chk("to_idle_ready", cmd_ready, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
